half_adder: RTL and testbench

//   Registered half adder: computes sum = a ^ b and carry = a & b for WIDTH independent
//   1-bit lanes. Results appear one clock after a qualified input.

---
 rtl/half_adder_pkg.sv | 11 +
 rtl/half_adder_cell.sv | 13 +
 rtl/half_adder.sv | 54 +++++
 tb/tb_half_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared definitions for the registered half adder: default lane count and
// the single-lane reference function {carry, sum}.
package half_adder_pkg;

  localparam int HA_DEFAULT_WIDTH = 1;

  function automatic logic [1:0] ha_ref(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Combinational 1-bit half adder lane; the top registers its outputs.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign {carry, sum} = ha_ref(a, b);

endmodule

// File: rtl/half_adder.sv
// Registered half adder over WIDTH independent lanes; results one clock after
// a qualified input, all outputs straight from flops.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = HA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH-1:0] carry_p0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum_p0[i]),
      .carry (carry_p0[i])
    );
  end

  // p0 -> p1: output register stage; idle cycles hold the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_p0;
        carry <= carry_p0;
      end
    end
  end

  a_excl: assert property (@(posedge clk)
    (!rst && in_valid) |-> ((sum_p0 & carry_p0) == '0));

  a_vld: assert property (@(posedge clk)
    !rst |=> (out_valid == $past(in_valid)));

  a_rst: assert property (@(posedge clk)
    rst |=> (!out_valid && sum == '0 && carry == '0));

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder at WIDTH=1, 4 and 8 against an arithmetic lane model.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, iv1 = 1'b0, ov1;
  logic [0:0] a1 = '0, b1 = '0, s1, c1;
  logic       rst4 = 1'b1, iv4 = 1'b0, ov4;
  logic [3:0] a4 = '0, b4 = '0, s4, c4;
  logic       rst8 = 1'b1, iv8 = 1'b0, ov8;
  logic [7:0] a8 = '0, b8 = '0, s8, c8;

  int tests = 0;
  int fails = 0;

  half_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .in_valid(iv1), .a(a1), .b(b1),
                                .out_valid(ov1), .sum(s1), .carry(c1));
  half_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .in_valid(iv4), .a(a4), .b(b4),
                                .out_valid(ov4), .sum(s4), .carry(c4));
  half_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .in_valid(iv8), .a(a8), .b(b8),
                                .out_valid(ov8), .sum(s8), .carry(c8));

  // Each lane adds two bits arithmetically: low bit is sum, high bit is carry.
  function automatic void lane_model(input logic [7:0] a, input logic [7:0] b, input int w,
                                     output logic [7:0] s, output logic [7:0] c);
    s = '0;
    c = '0;
    for (int i = 0; i < w; i++) begin
      int t;
      t = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst1 = 1'b1; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      tests++;
      if ({ov1, s1, c1} !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got v/s/c=%b want 000", k, {ov1, s1, c1});
      end
    end
    rst1 = 1'b0;
    tick;
    tests++;
    if ({ov1, s1, c1} !== 3'b101) begin
      fails++;
      $display("FAIL reset_release: got v/s/c=%b want 101", {ov1, s1, c1});
    end
  endtask

  task automatic test_truth;
    logic [7:0] es, ec;
    logic [1:0] p;
    iv1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p = 2'(k);
      a1 = p[1]; b1 = p[0];
      lane_model({7'd0, a1}, {7'd0, b1}, 1, es, ec);
      tick;
      tests++;
      if ({ov1, s1, c1} !== {1'b1, es[0], ec[0]}) begin
        fails++;
        $display("FAIL truth ab=%b: got v/s/c=%b want %b", p, {ov1, s1, c1},
                 {1'b1, es[0], ec[0]});
      end
    end
  endtask

  task automatic test_hold;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    tick;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    tick;
    tests++;
    if ({ov1, s1, c1} !== 3'b001) begin
      fails++;
      $display("FAIL hold_idle: got v/s/c=%b want 001", {ov1, s1, c1});
    end
    a1 = 1'bx; b1 = 1'bx;
    tick;
    tests++;
    if ({ov1, s1, c1} !== 3'b001) begin
      fails++;
      $display("FAIL hold_x: got v/s/c=%b want 001", {ov1, s1, c1});
    end
  endtask

  task automatic test_lanes4;
    rst4 = 1'b1; iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    tick;
    tests++;
    if ({ov4, s4, c4} !== 9'd0) begin
      fails++;
      $display("FAIL lanes4_reset: got v=%b s=%b c=%b want 0", ov4, s4, c4);
    end
    rst4 = 1'b0; a4 = 4'b1100; b4 = 4'b1010;
    tick;
    tests++;
    if ({ov4, s4, c4} !== {1'b1, 4'b0110, 4'b1000}) begin
      fails++;
      $display("FAIL lanes4: got v=%b s=%b c=%b want v=1 s=0110 c=1000", ov4, s4, c4);
    end
    iv4 = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [7:0] es, ec;
    logic ev;
    rst8 = 1'b1;
    tick;
    rst8 = 1'b0; iv8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      rst8 = (k == 4);
      if (rst8) begin
        es = '0; ec = '0; ev = 1'b0;
      end else begin
        lane_model(a8, b8, 8, es, ec); ev = 1'b1;
      end
      tick;
      tests++;
      if ({ov8, s8, c8} !== {ev, es, ec}) begin
        fails++;
        $display("FAIL mid_reset cyc%0d: got v=%b s=%h c=%h want v=%b s=%h c=%h",
                 k, ov8, s8, c8, ev, es, ec);
      end
    end
    rst8 = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] es, ec, ts, tc;
    logic ev;
    rst8 = 1'b1;
    tick;
    rst8 = 1'b0;
    es = '0; ec = '0;
    for (int k = 0; k < 1000; k++) begin
      iv8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom); b8 = 8'($urandom);
      ev = iv8;
      if (iv8) begin
        lane_model(a8, b8, 8, ts, tc);
        es = ts; ec = tc;
      end
      tick;
      tests++;
      if ({ov8, s8, c8} !== {ev, es, ec}) begin
        fails++;
        $display("FAIL random cyc%0d: got v=%b s=%h c=%h want v=%b s=%h c=%h",
                 k, ov8, s8, c8, ev, es, ec);
      end
      tests++;
      if ((s8 & c8) !== 8'h00) begin
        fails++;
        $display("FAIL exclusive cyc%0d: got s&c=%h want 00", k, s8 & c8);
      end
    end
    iv8 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_truth;
    test_hold;
    test_lanes4;
    test_mid_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
